// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter among N_REQ byte producers.
// Round-robin arbitration, optional lock for multi-byte messages, and a
// watchdog that aborts a byte the transmitter never completes.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req, lock, data   per-requester byte-valid, keep-grant flag, packed bytes
//   ack               one-cycle pulse to the requester whose byte finished
//   tx_start, tx_data start pulse and byte towards the transmitter
//   tx_busy, tx_done  transmitter status and stop-bit-finished pulse
//   grant_id          index of current/last owner
//   timeout_err       one-cycle pulse on watchdog abort
module uart_tx_scheduler #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 2047
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ-1:0]            lock,
   input  logic [N_REQ*DATA_W-1:0]     data,
   output logic [N_REQ-1:0]            ack,
   output logic                        tx_start,
   output logic [DATA_W-1:0]           tx_data,
   input  logic                        tx_busy,
   input  logic                        tx_done,
   output logic [$clog2(N_REQ)-1:0]    grant_id,
   output logic                        timeout_err
);

   localparam int unsigned ID_W = $clog2(N_REQ);
   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state, w_state;
   logic [ID_W-1:0]     r_ptr, w_ptr;
   logic                r_locked, w_locked;
   logic [ID_W-1:0]     r_grant, w_grant;
   logic [DATA_W-1:0]   r_tx_data, w_tx_data;
   logic [WD_W-1:0]     r_wd, w_wd;
   logic [N_REQ-1:0]    r_ack, w_ack;
   logic                r_tx_start, w_tx_start;
   logic                r_timeout, w_timeout;

   logic [DATA_W-1:0]   w_bytes [N_REQ];
   logic [ID_W-1:0]     w_arb_win;
   logic                w_arb_hit;
   logic [ID_W-1:0]     w_win;
   int unsigned         w_idx;

   // Unpack the flat data bus into one byte per requester.
   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_bytes[g] = data[g*DATA_W +: DATA_W];
   end

   // Winner: the locked owner if it still requests, else first req at or after ptr.
   always_comb begin
      w_arb_win = '0;
      w_arb_hit = 1'b0;
      w_idx     = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         w_idx = (32'(r_ptr) + k) % N_REQ;
         if (!w_arb_hit && req[ID_W'(w_idx)]) begin
            w_arb_hit = 1'b1;
            w_arb_win = ID_W'(w_idx);
         end
      end
      w_win = (r_locked && req[r_grant]) ? r_grant : w_arb_win;
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state    = r_state;
      w_ptr      = r_ptr;
      w_locked   = r_locked;
      w_grant    = r_grant;
      w_tx_data  = r_tx_data;
      w_wd       = r_wd;
      w_ack      = '0;
      w_tx_start = 1'b0;
      w_timeout  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // An owner that dropped req loses its lock; arbitration stays normal.
            if (r_locked && !req[r_grant]) w_locked = 1'b0;
            if ((|req) && !tx_busy) begin
               w_tx_data  = w_bytes[w_win];
               w_grant    = w_win;
               w_ptr      = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + ID_W'(1);
               w_locked   = lock[w_win];
               w_wd       = '0;
               w_tx_start = 1'b1;
               w_state    = S_START;
            end
         end
         S_START: begin
            // wd counts cycles since tx_start, so it reaches TIMEOUT after TIMEOUT waits.
            w_wd    = r_wd + WD_W'(1);
            w_state = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done) begin
               w_ack   = N_REQ'(1) << r_grant;
               w_state = S_DONE;
            end else if (r_wd == WD_W'(TIMEOUT)) begin
               w_timeout = 1'b1;
               w_locked  = 1'b0;
               w_state   = S_IDLE;
            end else begin
               w_wd = r_wd + WD_W'(1);
            end
         end
         S_DONE: begin
            w_locked = lock[r_grant];
            w_state  = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_locked   <= 1'b0;
         r_grant    <= '0;
         r_tx_data  <= '0;
         r_wd       <= '0;
         r_ack      <= '0;
         r_tx_start <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_ptr      <= w_ptr;
         r_locked   <= w_locked;
         r_grant    <= w_grant;
         r_tx_data  <= w_tx_data;
         r_wd       <= w_wd;
         r_ack      <= w_ack;
         r_tx_start <= w_tx_start;
         r_timeout  <= w_timeout;
      end
   end

   assign ack         = r_ack;
   assign tx_start    = r_tx_start;
   assign tx_data     = r_tx_data;
   assign grant_id    = r_grant;
   assign timeout_err = r_timeout;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: random requesters and a random transmitter around
// uart_tx_scheduler, checked cycle by cycle against a reference model built
// from the arbitration, lock, latency and watchdog rules.
module tb_uart_tx_scheduler;

   localparam int N       = 4;
   localparam int DW      = 8;
   localparam int TO      = 40;
   localparam int NCYC    = 4000;
   localparam int RST_CYC = 2500;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req, lock, ack;
   logic [N*DW-1:0] data;
   logic          tx_start, tx_busy, tx_done, timeout_err;
   logic [DW-1:0] tx_data;
   logic [1:0]    grant_id;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .data(data), .ack(ack),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
      .grant_id(grant_id), .timeout_err(timeout_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Per-requester byte queues (circular, 256 deep) with a lock flag per byte.
   logic [DW-1:0] mbyte [N][256];
   logic          mlock [N][256];
   int            hd [N];
   int            tl [N];

   // Reference model state.
   int  cyc, m_ptr, m_owner, exp_win, s_cyc, ack_cyc, done_at;
   bit  m_locked, m_idle, exp_start, inflight, done_got;
   bit  nx_done, nx_busy, busy_ext, did_rst, exp_to, first;
   bit  next_idle, next_start;
   logic [N-1:0] exp_ack;

   function automatic int pick(input logic [N-1:0] r);
      if (m_locked && r[m_owner]) return m_owner;
      for (int k = 0; k < N; k++)
         if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return 0;
   endfunction

   task automatic add_msg(input int i);
      int len;
      len = int'($urandom_range(3, 1));
      for (int k = 0; k < len; k++) begin
         mbyte[i][tl[i] % 256] = 8'($urandom);
         mlock[i][tl[i] % 256] = (k != len - 1);
         tl[i]++;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req[i]            = (hd[i] != tl[i]);
         lock[i]           = req[i] ? mlock[i][hd[i] % 256] : 1'b0;
         data[i*DW +: DW]  = mbyte[i][hd[i] % 256];
      end
      tx_done = nx_done;
      tx_busy = nx_busy;
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_ack"},      32'(ack),         32'd0);
      chk({tag, "_tx_start"}, 32'(tx_start),    32'd0);
      chk({tag, "_tx_data"},  32'(tx_data),     32'd0);
      chk({tag, "_grant_id"}, 32'(grant_id),    32'd0);
      chk({tag, "_timeout"},  32'(timeout_err), 32'd0);
   endtask

   initial begin
      rst = 1'b1; req = '0; lock = '0; data = '0; tx_busy = 1'b0; tx_done = 1'b0;
      for (int i = 0; i < N; i++) begin
         hd[i] = 0; tl[i] = 0;
         for (int j = 0; j < 256; j++) begin mbyte[i][j] = '0; mlock[i][j] = 1'b0; end
      end
      // First byte: requester 0 alone sends 'A', transmitter answers after 10 cycles.
      mbyte[0][0] = 8'h41; mlock[0][0] = 1'b0; tl[0] = 1;
      m_ptr = 0; m_owner = 0; m_locked = 0; m_idle = 1; exp_start = 0;
      inflight = 0; done_got = 0; nx_done = 0; nx_busy = 0; busy_ext = 0;
      did_rst = 0; first = 1; done_at = -1; s_cyc = 0; ack_cyc = 0; exp_win = 0;
      repeat (3) @(posedge clk);
      #1 rst_chk("reset");
      @(negedge clk) rst = 1'b0;

      for (cyc = 1; cyc <= NCYC; cyc++) begin
         @(posedge clk);
         #1 drive();
         @(negedge clk);

         chk("tx_start", 32'(tx_start), 32'(exp_start));
         if (exp_start) begin
            chk("grant_id", 32'(grant_id), 32'(exp_win));
            chk("tx_data", 32'(tx_data), 32'(mbyte[exp_win][hd[exp_win] % 256]));
            m_owner = exp_win; inflight = 1; done_got = 0; s_cyc = cyc;
            if (first) begin
               done_at = cyc + 10; first = 0;
            end else begin
               case ($urandom_range(7, 0))
                  0:       done_at = -1;
                  1:       done_at = cyc + TO;
                  default: done_at = cyc + int'($urandom_range(12, 1));
               endcase
            end
         end

         exp_ack = (inflight && done_got && cyc == ack_cyc) ? (N'(1) << m_owner) : '0;
         chk("ack", 32'(ack), 32'(exp_ack));
         exp_to = inflight && !done_got && (cyc == s_cyc + TO + 1);
         chk("timeout_err", 32'(timeout_err), 32'(exp_to));
         if (exp_to) begin m_locked = 0; inflight = 0; end

         next_idle = 0; next_start = 0;
         if (inflight && !done_got && cyc > s_cyc) begin
            if (tx_done) begin done_got = 1; ack_cyc = cyc + 1; end
            else if (cyc == s_cyc + TO) next_idle = 1;
         end else if (inflight && done_got && cyc == ack_cyc) begin
            m_locked = lock[m_owner]; hd[m_owner]++; inflight = 0; next_idle = 1;
         end

         if (m_idle) begin
            if (m_locked && !req[m_owner]) m_locked = 0;
            if ((|req) && !tx_busy) begin
               exp_win  = pick(req);
               m_ptr    = (exp_win + 1) % N;
               m_locked = lock[exp_win];
               next_start = 1;
            end else begin
               next_idle = 1;
            end
         end
         m_idle = next_idle; exp_start = next_start;

         // Transmitter and requester behaviour for the next cycle.
         if (inflight && !done_got) nx_done = (done_at == cyc + 1);
         else nx_done = (cyc > 20) && ($urandom_range(19, 0) == 0);
         if (cyc > 20 && $urandom_range(7, 0) == 0) busy_ext = !busy_ext;
         nx_busy = (inflight && !done_got) || busy_ext;
         if (cyc > 20)
            for (int i = 0; i < N; i++)
               if (hd[i] == tl[i] && $urandom_range(5, 0) == 0) add_msg(i);

         // Reset in the middle of a byte: outputs clear at once, rotation restarts.
         if (!did_rst && cyc >= RST_CYC && inflight && !done_got && cyc > s_cyc + 1) begin
            #2 rst = 1'b1;
            req = '0; lock = '0; data = '0; tx_done = 1'b0; tx_busy = 1'b0;
            #1 rst_chk("midrst");
            repeat (2) @(posedge clk);
            #1 rst_chk("midrst_hold");
            @(negedge clk) rst = 1'b0;
            m_ptr = 0; m_owner = 0; m_locked = 0; inflight = 0; done_got = 0;
            m_idle = 1; exp_start = 0; nx_done = 0; nx_busy = 0; busy_ext = 0;
            did_rst = 1;
         end
      end

      chk("midrst_reached", 32'(did_rst), 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
